bus_reader: RTL and testbench

//  Receiving end of the shared tri-state data bus. Arbitrates among N_SRC bus drivers,

---
 rtl/bus_reader_pkg.sv | 28 ++
 rtl/bus_reader_if.sv | 33 +++
 rtl/bus_reader_fifo.sv | 63 ++++++
 rtl/bus_reader.sv | 131 +++++++++++++
 tb/tb_bus_reader.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_reader_pkg.sv
// Shared types and helpers for the bus_reader slice: FSM state encoding,
// default sizes and a constant-foldable clog2.
package bus_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_TURN    = 2'd3
    } state_t;

    localparam int DEF_N_SRC = 4;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

    // Bits needed to index 'value' items (clog2(1) == 0).
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/bus_reader_if.sv
// Signal bundle between bus_reader and its surroundings: requests and drive
// enables toward the bus drivers, the shared bus value, and the valid/ready
// drain side. master = bus_reader, slave = drivers/consumer.
interface bus_reader_if
    import bus_reader_pkg::*;
#(
    parameter int N_SRC = DEF_N_SRC,
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) ();
    localparam int SRC_W = clog2(N_SRC);
    localparam int LVL_W = clog2(DEPTH) + 1;

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] en;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] out_data;
    logic [SRC_W-1:0] out_src;
    logic             out_valid;
    logic             out_ready;
    logic [LVL_W-1:0] level;

    modport master (
        input  req, bus_in, out_ready,
        output en, out_data, out_src, out_valid, level
    );

    modport slave (
        output req, bus_in, out_ready,
        input  en, out_data, out_src, out_valid, level
    );

endinterface

// File: rtl/bus_reader_fifo.sv
// Synchronous FIFO holding captured {src,data} entries. Head is shown
// combinationally; push into a full FIFO and pop from an empty one are ignored.
module bus_reader_fifo
    import bus_reader_pkg::*;
#(
    parameter int ENTRY_W = 6,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LVL_W   = clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic               valid,
    output logic [LVL_W-1:0]   level
);
    localparam int PTR_W = clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && (count != LVL_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is cleared too because the head word is visible
            // on out_data and must read 0 straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);
    assign level = count;

endmodule

// File: rtl/bus_reader.sv
// bus_reader: arbitrates among N_SRC tri-state bus drivers, enables exactly
// one at a time for two cycles, captures the settled bus into a FIFO and
// hands words out over valid/ready tagged with the source index.
// Optional feature: define BUS_READER_TURNAROUND_EN to add one released
// (TURN) cycle after each capture, giving two idle bus cycles per handover.
module bus_reader
    import bus_reader_pkg::*;
#(
    parameter int N_SRC = DEF_N_SRC,
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_reader_if.master  bus
);
    localparam int SRC_W   = clog2(N_SRC);
    localparam int LVL_W   = clog2(DEPTH) + 1;
    localparam int ENTRY_W = SRC_W + WIDTH;

    state_t             state;
    state_t             next_state;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   next_grant;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   pick_idx;
    logic [SRC_W-1:0]   cand;
    logic               pick_valid;
    logic [N_SRC-1:0]   en_q;
    logic [N_SRC-1:0]   next_en;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic               fifo_valid;
    logic [LVL_W-1:0]   fifo_level;

    // Round-robin pick: first requester after rr_ptr, wrapping mod N_SRC.
    // NOTE: every signal gets a default first so no latch can be inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        // Scan farthest-to-nearest so the nearest requester is written last.
        for (int i = N_SRC; i >= 1; i--) begin
            cand = SRC_W'((int'(rr_ptr) + i) % N_SRC);
            if (bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state logic, capture strobe and the decoded enable for next cycle.
    always_comb begin
        next_state = state;
        next_grant = grant_idx;
        push       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid && (fifo_level < LVL_W'(DEPTH))) begin
                    next_state = ST_GRANT;
                    next_grant = pick_idx;
                end
            end
            ST_GRANT: begin
                next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                push = 1'b1;
`ifdef BUS_READER_TURNAROUND_EN
                next_state = ST_TURN;
`else
                next_state = ST_IDLE;
`endif
            end
            ST_TURN: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        next_en = '0;
        if ((next_state == ST_GRANT) || (next_state == ST_CAPTURE)) begin
            next_en = {{(N_SRC-1){1'b0}}, 1'b1} << next_grant;
        end
    end

    // State, grant, arbitration pointer and registered enable; reset releases
    // the bus immediately and abandons any in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant_idx <= '0;
            rr_ptr    <= SRC_W'(N_SRC - 1);
            en_q      <= '0;
        end else begin
            state     <= next_state;
            grant_idx <= next_grant;
            en_q      <= next_en;
            if (state == ST_CAPTURE) begin
                rr_ptr <= grant_idx;
            end
        end
    end

    assign pop = fifo_valid && bus.out_ready;

    bus_reader_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH),
        .LVL_W   (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({grant_idx, bus.bus_in}),
        .pop       (pop),
        .head      (head),
        .valid     (fifo_valid),
        .level     (fifo_level)
    );

    assign bus.en        = en_q;
    assign bus.out_data  = head[WIDTH-1:0];
    assign bus.out_src   = head[ENTRY_W-1:WIDTH];
    assign bus.out_valid = fifo_valid;
    assign bus.level     = fifo_level;

endmodule

// File: tb/tb_bus_reader.sv
// Directed bench for bus_reader: reset, single transfer, round-robin order,
// FIFO full back-pressure, reset mid-capture and the inter-driver gap.
module tb_bus_reader;
    import bus_reader_pkg::*;

    localparam int N_SRC = 4;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    bus_reader_if #(.N_SRC(N_SRC), .WIDTH(WIDTH), .DEPTH(DEPTH)) bif ();

    bus_reader #(.N_SRC(N_SRC), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int idx_of(input logic [N_SRC-1:0] v);
        for (int i = 0; i < N_SRC; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bif.req       = '0;
        bif.out_ready = 1'b0;
        bif.bus_in    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for any enable bit; returns at the negedge it is seen.
    task automatic wait_en(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bif.en !== '0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Waits (bounded) for the enables to drop back to zero.
    task automatic wait_en_low(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bif.en === '0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bif.req       = '0;
        bif.out_ready = 1'b0;
        bif.bus_in    = 4'h3;
        rst_n         = 1'b0;
        #1;
        tests_run++;
        if (bif.en !== 4'b0000 || bif.out_valid !== 1'b0 || bif.level !== 3'd0 ||
            bif.out_data !== 4'h0 || bif.out_src !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_values: en=%b valid=%b level=%0d data=%h src=%0d required 0000/0/0/0/0",
                     bif.en, bif.out_valid, bif.level, bif.out_data, bif.out_src);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bif.bus_in = ~bif.bus_in;
            tests_run++;
            if (bif.en !== 4'b0000) begin
                tests_failed++;
                $display("FAIL idle_en cycle %0d: got %b required 0000", c, bif.en);
            end
            tests_run++;
            if (bif.out_valid !== 1'b0 || bif.level !== 3'd0) begin
                tests_failed++;
                $display("FAIL idle_fifo cycle %0d: valid=%b level=%0d required 0/0",
                         c, bif.out_valid, bif.level);
            end
        end
    endtask

    task automatic test_single();
        bit seen;
        int cnt;
        @(negedge clk);
        bif.req    = 4'b0100;
        bif.bus_in = 4'hA;
        wait_en(10, seen);
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL single_grant_timeout: got no enable required 0100");
        end
        tests_run++;
        if (bif.en !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_en: got %b required 0100", bif.en);
        end
        bif.req = '0;
        cnt = 1;
        @(negedge clk);
        while (bif.en === 4'b0100 && cnt < 6) begin
            cnt++;
            @(negedge clk);
        end
        tests_run++;
        if (cnt !== 2) begin
            tests_failed++;
            $display("FAIL single_en_len: got %0d cycles required 2", cnt);
        end
        tests_run++;
        if (bif.en !== 4'b0000 || bif.out_valid !== 1'b1 || bif.out_data !== 4'hA ||
            bif.out_src !== 2'd2 || bif.level !== 3'd1) begin
            tests_failed++;
            $display("FAIL single_capture: en=%b valid=%b data=%h src=%0d level=%0d required 0000/1/a/2/1",
                     bif.en, bif.out_valid, bif.out_data, bif.out_src, bif.level);
        end
        bif.out_ready = 1'b1;
        @(negedge clk);
        bif.out_ready = 1'b0;
        tests_run++;
        if (bif.level !== 3'd0 || bif.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_pop: level=%0d valid=%b required 0/0", bif.level, bif.out_valid);
        end
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int got_order [5] = '{-1, -1, -1, -1, -1};
        int n_grants;
        logic [N_SRC-1:0] prev;
        apply_reset();
        bif.out_ready = 1'b1;
        bif.bus_in    = 4'h5;
        bif.req       = 4'b1111;
        n_grants = 0;
        prev     = '0;
        for (int c = 0; c < 40 && n_grants < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if ($countones(bif.en) > 1) begin
                tests_failed++;
                $display("FAIL rr_onehot cycle %0d: got %b required at most one bit", c, bif.en);
            end
            tests_run++;
            if (prev !== '0 && bif.en !== '0 && bif.en !== prev) begin
                tests_failed++;
                $display("FAIL rr_gap cycle %0d: got %b after %b required 0000 between", c, bif.en, prev);
            end
            if (bif.out_valid === 1'b1) begin
                tests_run++;
                if (bif.out_data !== 4'h5) begin
                    tests_failed++;
                    $display("FAIL rr_data cycle %0d: got %h required 5", c, bif.out_data);
                end
            end
            if (bif.en !== '0 && prev === '0) begin
                got_order[n_grants] = idx_of(bif.en);
                n_grants++;
            end
            prev = bif.en;
        end
        bif.req = '0;
        for (int g = 0; g < 5; g++) begin
            tests_run++;
            if (got_order[g] != exp_order[g]) begin
                tests_failed++;
                $display("FAIL rr_order grant %0d: got %0d required %0d", g, got_order[g], exp_order[g]);
            end
        end
    endtask

    task automatic test_full();
        logic [3:0] words [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        bit seen;
        apply_reset();
        bif.out_ready = 1'b0;
        bif.req       = 4'b0001;
        for (int w = 0; w < 4; w++) begin
            wait_en(10, seen);
            tests_run++;
            if (!seen) begin
                tests_failed++;
                $display("FAIL full_fill_timeout word %0d: got no enable required 0001", w);
            end
            bif.bus_in = words[w];
            wait_en_low(5, seen);
        end
        tests_run++;
        if (bif.level !== 3'd4 || bif.out_valid !== 1'b1 || bif.out_data !== 4'h1 ||
            bif.out_src !== 2'd0) begin
            tests_failed++;
            $display("FAIL full_state: level=%0d valid=%b data=%h src=%0d required 4/1/1/0",
                     bif.level, bif.out_valid, bif.out_data, bif.out_src);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests_run++;
            if (bif.en !== 4'b0000 || bif.level !== 3'd4) begin
                tests_failed++;
                $display("FAIL full_stall cycle %0d: en=%b level=%0d required 0000/4", c, bif.en, bif.level);
            end
        end
        bif.out_ready = 1'b1;
        @(negedge clk);
        bif.out_ready = 1'b0;
        tests_run++;
        if (bif.level !== 3'd3 || bif.out_data !== 4'h2) begin
            tests_failed++;
            $display("FAIL full_pop: level=%0d data=%h required 3/2", bif.level, bif.out_data);
        end
        wait_en(5, seen);
        tests_run++;
        if (!seen || bif.en !== 4'b0001) begin
            tests_failed++;
            $display("FAIL full_regrant: got %b required 0001", bif.en);
        end
        bif.req = '0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        apply_reset();
        bif.out_ready = 1'b0;
        bif.bus_in    = 4'h7;
        bif.req       = 4'b0001;
        wait_en(10, seen);
        wait_en_low(5, seen);
        tests_run++;
        if (bif.level !== 3'd1) begin
            tests_failed++;
            $display("FAIL mid_first_word: level=%0d required 1", bif.level);
        end
        wait_en(10, seen);
        @(negedge clk);
        tests_run++;
        if (bif.en !== 4'b0001) begin
            tests_failed++;
            $display("FAIL mid_capture_en: got %b required 0001", bif.en);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bif.en !== 4'b0000 || bif.level !== 3'd0 || bif.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: en=%b level=%0d valid=%b required 0000/0/0",
                     bif.en, bif.level, bif.out_valid);
        end
        bif.req = 4'b0011;
        @(negedge clk);
        rst_n = 1'b1;
        wait_en(5, seen);
        tests_run++;
        if (!seen || bif.en !== 4'b0001) begin
            tests_failed++;
            $display("FAIL mid_first_after_reset: got %b required 0001", bif.en);
        end
        bif.req = '0;
    endtask

    task automatic test_gap();
        logic [N_SRC-1:0] pat [6];
        bit seen;
`ifdef BUS_READER_TURNAROUND_EN
        logic [N_SRC-1:0] exp_pat [6] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0010};
        int exp_len = 6;
`else
        logic [N_SRC-1:0] exp_pat [6] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
        int exp_len = 5;
`endif
        apply_reset();
        bif.out_ready = 1'b1;
        bif.bus_in    = 4'h9;
        bif.req       = 4'b0011;
        wait_en(10, seen);
        pat[0] = bif.en;
        for (int i = 1; i < exp_len; i++) begin
            @(negedge clk);
            pat[i] = bif.en;
        end
        bif.req = '0;
        for (int i = 0; i < exp_len; i++) begin
            tests_run++;
            if (pat[i] !== exp_pat[i]) begin
                tests_failed++;
                $display("FAIL gap_pattern cycle %0d: got %b required %b", i, pat[i], exp_pat[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_reset_mid();
        test_gap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
